// File: rtl/sn_pkg.sv
// Shared constants and FSM state type for the SN operand loader slice.
package sn_pkg;

    localparam int unsigned SN_DATA_W     = 9;
    localparam int unsigned SN_FRAME_LEN  = 10;
    localparam int unsigned SN_EPOCH_LAST = 131072;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } sn_ldr_state_t;

endpackage

// File: rtl/sn_lane_shifter.sv
// One serial lane: LSB-first shift register plus check-bit evaluation.
// Macro SN_LOADER_PARITY_EN selects even parity over the data bits;
// without it the check bit must be 0.
module sn_lane_shifter #(
    parameter int unsigned DATA_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift_en,
    input  logic              ser_bit,
    output logic [DATA_W-1:0] data,
    output logic              check_ok
);

    // Shift right so that after DATA_W shifts bit 0 sits at data[0].
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            data <= '0;
        end else if (shift_en) begin
            data <= {ser_bit, data[DATA_W-1:1]};
        end
    end

    // ser_bit is interpreted as the check bit while the FSM is in CHECK.
    always_comb begin
`ifdef SN_LOADER_PARITY_EN
        check_ok = ((^data) == ser_bit);
`else
        check_ok = ~ser_bit;
`endif
    end

endmodule

// File: rtl/sn_operand_loader.sv
// Serial operand loader: receives paired frames into a shadow register
// and promotes them to the active operands at epoch boundaries.
// Optional feature macro: SN_LOADER_PARITY_EN (even-parity check bit).
// Note: reset port rst_n is active-high. DATA_W must be at least 2.
module sn_operand_loader
    import sn_pkg::*;
#(
    parameter int unsigned DATA_W    = SN_DATA_W,
    parameter int unsigned FRAME_LEN = SN_FRAME_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              ser_bit_1,
    input  logic              ser_bit_2,
    input  logic              epoch_end,
    output logic [DATA_W-1:0] operand_1,
    output logic [DATA_W-1:0] operand_2,
    output logic              loaded,
    output logic              pending,
    output logic              frame_err,
    output logic              overrun
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    sn_ldr_state_t     state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shadow_1;
    logic [DATA_W-1:0] shadow_2;
    logic [DATA_W-1:0] lane_data_1;
    logic [DATA_W-1:0] lane_data_2;
    logic              lane_ok_1;
    logic              lane_ok_2;
    logic              shift_en;
    logic              accept;
    logic              consume;

    // Lanes shift on every data-bit cycle, including a new frame's bit 0
    // arriving in CHECK or aborting a frame in SHIFT.
    always_comb begin
        shift_en = 1'b0;
        accept   = 1'b0;
        consume  = epoch_end & pending;
        case (state)
            IDLE:    shift_en = frame_start;
            SHIFT:   shift_en = 1'b1;
            CHECK: begin
                shift_en = frame_start;
                accept   = lane_ok_1 & lane_ok_2;
            end
            default: shift_en = 1'b0;
        endcase
    end

    sn_lane_shifter #(.DATA_W(DATA_W)) u_lane_1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .ser_bit  (ser_bit_1),
        .data     (lane_data_1),
        .check_ok (lane_ok_1)
    );

    sn_lane_shifter #(.DATA_W(DATA_W)) u_lane_2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .ser_bit  (ser_bit_2),
        .data     (lane_data_2),
        .check_ok (lane_ok_2)
    );

    // Frame FSM, shadow/operand handoff and registered status outputs.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shadow_1  <= '0;
            shadow_2  <= '0;
            operand_1 <= '0;
            operand_2 <= '0;
            loaded    <= 1'b0;
            pending   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            loaded    <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state   <= SHIFT;
                        bit_cnt <= CNT_W'(1);
                    end
                end
                SHIFT: begin
                    if (frame_start) begin
                        frame_err <= 1'b1;
                        bit_cnt   <= CNT_W'(1);
                    end else if (bit_cnt == LAST_BIT) begin
                        state <= CHECK;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (!accept) begin
                        frame_err <= 1'b1;
                    end
                    if (frame_start) begin
                        state   <= SHIFT;
                        bit_cnt <= CNT_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Old shadow moves out before a same-cycle accept refills it,
            // so pending stays set in that case.
            if (consume) begin
                operand_1 <= shadow_1;
                operand_2 <= shadow_2;
                loaded    <= 1'b1;
            end
            if (accept) begin
                shadow_1 <= lane_data_1;
                shadow_2 <= lane_data_2;
                pending  <= 1'b1;
                if (pending && !consume) begin
                    overrun <= 1'b1;
                end
            end else if (consume) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sn_operand_loader.sv
// Directed self-checking bench for sn_operand_loader.
module tb_sn_operand_loader;

    localparam int unsigned DW = 9;

    logic          clk;
    logic          rst_n;
    logic          frame_start;
    logic          ser_bit_1;
    logic          ser_bit_2;
    logic          epoch_end;
    logic [DW-1:0] operand_1;
    logic [DW-1:0] operand_2;
    logic          loaded;
    logic          pending;
    logic          frame_err;
    logic          overrun;

    int unsigned n_cmp;
    int unsigned n_bad;
    logic        err_at_start;

    sn_operand_loader #(.DATA_W(DW), .FRAME_LEN(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .ser_bit_1   (ser_bit_1),
        .ser_bit_2   (ser_bit_2),
        .epoch_end   (epoch_end),
        .operand_1   (operand_1),
        .operand_2   (operand_2),
        .loaded      (loaded),
        .pending     (pending),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Valid check bit for a data word in the current build.
    function automatic logic good_chk(input logic [DW-1:0] d);
`ifdef SN_LOADER_PARITY_EN
        return ^d;
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [DW-1:0] d1, input logic [DW-1:0] d2, input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = (i == 0);
            ser_bit_1   = d1[i];
            ser_bit_2   = d2[i];
            tick();
        end
        frame_start = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                              input logic c1, input logic c2, input logic ep);
        for (int i = 0; i < DW; i++) begin
            frame_start = (i == 0);
            ser_bit_1   = d1[i];
            ser_bit_2   = d2[i];
            tick();
            if (i == 0) err_at_start = frame_err;
        end
        frame_start = 1'b0;
        ser_bit_1   = c1;
        ser_bit_2   = c2;
        epoch_end   = ep;
        tick();
        ser_bit_1   = 1'b0;
        ser_bit_2   = 1'b0;
        epoch_end   = 1'b0;
    endtask

    task automatic pulse_epoch();
        epoch_end = 1'b1;
        tick();
        epoch_end = 1'b0;
    endtask

    task automatic ok_frame(input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic ep);
        send_frame(d1, d2, good_chk(d1), good_chk(d2), ep);
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        err_at_start = 1'b0;
        rst_n        = 1'b1;
        frame_start  = 1'b0;
        ser_bit_1    = 1'b0;
        ser_bit_2    = 1'b0;
        epoch_end    = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_op1", operand_1, 0);
        check("rst_op2", operand_2, 0);
        check("rst_loaded", loaded, 0);
        check("rst_pending", pending, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_overrun", overrun, 0);
        rst_n = 1'b0;
        tick();

        // Basic accept then epoch transfer
        ok_frame(9'h0A5, 9'h1FF, 1'b0);
        check("f1_pending", pending, 1);
        check("f1_ferr", frame_err, 0);
        check("f1_op1_hold", operand_1, 0);
        pulse_epoch();
        check("f1_loaded", loaded, 1);
        check("f1_op1", operand_1, 9'h0A5);
        check("f1_op2", operand_2, 9'h1FF);
        check("f1_pend_clr", pending, 0);
        tick();
        check("f1_loaded_once", loaded, 0);

        // Epoch with nothing pending
        pulse_epoch();
        check("ep_idle_loaded", loaded, 0);
        check("ep_idle_op1", operand_1, 9'h0A5);

        // Bad check bit on lane 2 only
        send_frame(9'h0F0, 9'h00F, good_chk(9'h0F0), ~good_chk(9'h00F), 1'b0);
        check("bad_ferr", frame_err, 1);
        check("bad_pending", pending, 0);
        tick();
        check("bad_ferr_pulse", frame_err, 0);
        pulse_epoch();
        check("bad_op1", operand_1, 9'h0A5);
        check("bad_op2", operand_2, 9'h1FF);

        // Overrun: two frames, no epoch between
        ok_frame(9'h003, 9'h003, 1'b0);
        check("ovr_first", overrun, 0);
        ok_frame(9'h004, 9'h004, 1'b0);
        check("ovr_set", overrun, 1);
        check("ovr_pending", pending, 1);
        pulse_epoch();
        check("ovr_op1", operand_1, 9'h004);
        tick();
        check("ovr_sticky", overrun, 1);

        // Reset at data bit 4 of a frame
        send_bits(9'h1B6, 9'h049, 4);
        frame_start = 1'b0;
        ser_bit_1   = 1'b1;
        ser_bit_2   = 1'b1;
        rst_n       = 1'b1;
        #2;
        check("arst_op1", operand_1, 0);
        check("arst_op2", operand_2, 0);
        check("arst_overrun", overrun, 0);
        check("arst_pending", pending, 0);
        check("arst_loaded", loaded, 0);
        check("arst_ferr", frame_err, 0);
        tick();
        rst_n = 1'b0;
        // No frame_start: lanes toggling must not produce a frame
        for (int i = 0; i < 12; i++) begin
            ser_bit_1 = i[0];
            ser_bit_2 = ~i[0];
            tick();
            if (frame_err) check("arst_noframe_ferr", frame_err, 0);
        end
        ser_bit_1 = 1'b0;
        ser_bit_2 = 1'b0;
        check("arst_no_pending", pending, 0);
        ok_frame(9'h1A3, 9'h05C, 1'b0);
        check("arst_new_pending", pending, 1);
        pulse_epoch();
        check("arst_new_op1", operand_1, 9'h1A3);
        check("arst_new_op2", operand_2, 9'h05C);

        // Accept coinciding with a consuming epoch
        ok_frame(9'h010, 9'h011, 1'b0);
        ok_frame(9'h020, 9'h021, 1'b1);
        check("co_loaded", loaded, 1);
        check("co_op1", operand_1, 9'h010);
        check("co_op2", operand_2, 9'h011);
        check("co_pending", pending, 1);
        check("co_overrun", overrun, 0);
        pulse_epoch();
        check("co_shadow_op1", operand_1, 9'h020);
        check("co_shadow_op2", operand_2, 9'h021);
        check("co_pend_clr", pending, 0);

        // Abort at data bit 5, then full frame 0x155
        send_bits(9'h0AA, 9'h0AA, 5);
        ok_frame(9'h155, 9'h0AA, 1'b0);
        check("abort_ferr", err_at_start, 1);
        check("abort_pending", pending, 1);
        check("abort_ferr_final", frame_err, 0);
        pulse_epoch();
        check("abort_op1", operand_1, 9'h155);
        check("abort_op2", operand_2, 9'h0AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
